// File: rtl/wb_ext_cpu_bridge_pkg.sv
// rtl/wb_ext_cpu_bridge_pkg.sv - shared types and lane helpers for the external CPU bridge
package wb_ext_cpu_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_RD_HOLD = 2'd2,
    ST_WR      = 2'd3
  } state_t;

  localparam int unsigned EXT_AW        = 13;
  localparam logic [7:0]  ERR_READ_BYTE = 8'hFF;

  // Big-endian lane numbering: byte address 0 lives on bits [31:24].
  function automatic logic [3:0] lane_sel(input logic [1:0] a);
    logic [3:0] s;
    case (a)
      2'd0:    s = 4'b1000;
      2'd1:    s = 4'b0100;
      2'd2:    s = 4'b0010;
      default: s = 4'b0001;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] a);
    logic [7:0] b;
    case (a)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wb_ext_cpu_bridge_if.sv
// rtl/wb_ext_cpu_bridge_if.sv - Wishbone bus bundle between the bridge and the conbus
interface wb_ext_cpu_bridge_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;

  modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack);
  modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack);
endinterface

// File: rtl/wb_ext_cpu_bridge_ext_bus_sync.sv
// rtl/wb_ext_cpu_bridge_ext_bus_sync.sv - synchronizers and strobe edge detection for the host bus
module wb_ext_cpu_bridge_ext_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic ncs,
  input  logic noe,
  input  logic nwe,
  output logic ncs_s,
  output logic noe_s,
  output logic nwe_s,
  output logic rd_start,
  output logic wr_end
);

  // Bit order {ncs, noe, nwe}; idle level of every strobe is high.
  logic [2:0] meta;
  logic [2:0] sync;
  logic       rd_prev;
  logic       nwe_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= 3'b111;
      sync     <= 3'b111;
      rd_prev  <= 1'b0;
      nwe_prev <= 1'b1;
    end else begin
      meta     <= {ncs, noe, nwe};
      sync     <= meta;
      rd_prev  <= ~sync[2] & ~sync[1];
      nwe_prev <= sync[0];
    end
  end

  assign ncs_s    = sync[2];
  assign noe_s    = sync[1];
  assign nwe_s    = sync[0];
  assign rd_start = ~ncs_s & ~noe_s & ~rd_prev;
  assign wr_end   = nwe_s & ~nwe_prev & ~ncs_s;

endmodule

// File: rtl/wb_ext_cpu_bridge.sv
// rtl/wb_ext_cpu_bridge.sv - external 8-bit host bus to single 32-bit Wishbone cycles
module wb_ext_cpu_bridge
  import wb_ext_cpu_bridge_pkg::*;
#(
  parameter logic [31:0] base_addr      = 32'h40000000,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [EXT_AW-1:0] ext_addr,
  input  logic [7:0]        ext_data_i,
  output logic [7:0]        ext_data_o,
  output logic              ext_data_oe,
  input  logic              ext_ncs,
  input  logic              ext_noe,
  input  logic              ext_nwe,
  output logic              ext_nwait,
  output logic              timeout_o,
  wb_ext_cpu_bridge_if.master wb
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(timeout_cycles - 1);

  logic   ncs_s;
  logic   noe_s;
  logic   nwe_s;
  logic   rd_start;
  logic   wr_end;
  logic   host_reading;
  logic   expired;
  state_t state;
  logic [15:0] cnt;

  wb_ext_cpu_bridge_ext_bus_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .ncs      (ext_ncs),
    .noe      (ext_noe),
    .nwe      (ext_nwe),
    .ncs_s    (ncs_s),
    .noe_s    (noe_s),
    .nwe_s    (nwe_s),
    .rd_start (rd_start),
    .wr_end   (wr_end)
  );

  assign host_reading = ~ncs_s & ~noe_s;
  assign expired      = (cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= 16'd0;
      wb.adr      <= 32'd0;
      wb.dat_w    <= 32'd0;
      wb.sel      <= 4'd0;
      wb.we       <= 1'b0;
      wb.cyc      <= 1'b0;
      wb.stb      <= 1'b0;
      ext_data_o  <= 8'd0;
      ext_data_oe <= 1'b0;
      ext_nwait   <= 1'b1;
      timeout_o   <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          ext_data_oe <= 1'b0;
          ext_nwait   <= 1'b1;
          // A write completing in the same clock as a read start wins;
          // the read is retried by the host on its next strobe.
          if (wr_end) begin
            wb.adr    <= {base_addr[31:EXT_AW], ext_addr};
            wb.sel    <= lane_sel(ext_addr[1:0]);
            wb.dat_w  <= {4{ext_data_i}};
            wb.we     <= 1'b1;
            wb.cyc    <= 1'b1;
            wb.stb    <= 1'b1;
            ext_nwait <= 1'b0;
            cnt       <= 16'd0;
            state     <= ST_WR;
          end else if (rd_start) begin
            wb.adr    <= {base_addr[31:EXT_AW], ext_addr};
            wb.sel    <= lane_sel(ext_addr[1:0]);
            wb.we     <= 1'b0;
            wb.cyc    <= 1'b1;
            wb.stb    <= 1'b1;
            ext_nwait <= 1'b0;
            cnt       <= 16'd0;
            state     <= ST_RD;
          end
        end

        ST_WR: begin
          if (wb.ack || expired) begin
            wb.cyc    <= 1'b0;
            wb.stb    <= 1'b0;
            wb.we     <= 1'b0;
            ext_nwait <= 1'b1;
            timeout_o <= ~wb.ack;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ST_RD: begin
          // The bus cycle always runs to ack or timeout; if the host already
          // let go, the data is simply never driven onto the pads.
          if (wb.ack || expired) begin
            wb.cyc      <= 1'b0;
            wb.stb      <= 1'b0;
            ext_nwait   <= 1'b1;
            ext_data_o  <= wb.ack ? lane_byte(wb.dat_r, wb.adr[1:0]) : ERR_READ_BYTE;
            timeout_o   <= ~wb.ack;
            ext_data_oe <= host_reading;
            state       <= host_reading ? ST_RD_HOLD : ST_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ST_RD_HOLD: begin
          ext_data_oe <= host_reading;
          if (!host_reading) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ext_cpu_bridge.sv
// tb/tb_wb_ext_cpu_bridge.sv - directed scoreboard bench for the external CPU bridge
module tb_wb_ext_cpu_bridge;

  localparam logic [31:0] BASE = 32'h40000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] ext_addr = 13'd0;
  logic [7:0]  ext_data_i = 8'd0;
  logic [7:0]  ext_data_o;
  logic        ext_data_oe;
  logic        ext_ncs = 1'b1;
  logic        ext_noe = 1'b1;
  logic        ext_nwe = 1'b1;
  logic        ext_nwait;
  logic        timeout_o;

  wb_ext_cpu_bridge_if wb ();

  wb_ext_cpu_bridge #(.base_addr(BASE), .timeout_cycles(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .ext_addr    (ext_addr),
    .ext_data_i  (ext_data_i),
    .ext_data_o  (ext_data_o),
    .ext_data_oe (ext_data_oe),
    .ext_ncs     (ext_ncs),
    .ext_noe     (ext_noe),
    .ext_nwe     (ext_nwe),
    .ext_nwait   (ext_nwait),
    .timeout_o   (timeout_o),
    .wb          (wb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        we;
  } wb_txn_t;

  wb_txn_t    wb_q[$];
  logic [7:0] rd_q[$];
  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wishbone slave: word memory, programmable ack delay, optional silence.
  logic [31:0] mem [0:2047];
  int ack_delay = 0;
  bit no_ack = 1'b0;
  int wait_cnt;
  bit mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++) mem[i] <= (i == 0) ? 32'h11223344 : 32'h0;
      mem_ready <= 1'b1;
    end
    if (reset || !(wb.cyc && wb.stb)) begin
      wb.ack   <= 1'b0;
      wait_cnt <= 0;
    end else if (wb.ack) begin
      wb.ack <= 1'b0;
    end else if (!no_ack && wait_cnt >= ack_delay) begin
      wb.ack <= 1'b1;
      if (wb.we) begin
        for (int b = 0; b < 4; b++)
          if (wb.sel[b]) mem[wb.adr[12:2]][b*8 +: 8] <= wb.dat_w[b*8 +: 8];
      end else begin
        wb.dat_r <= mem[wb.adr[12:2]];
      end
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // Monitor: scoreboard pop on each new cycle, plus event counters.
  bit      seen = 1'b0;
  int      cyc_cnt = 0;
  int      to_cnt = 0;
  int      oe_cnt = 0;
  int      ack_cnt = 0;
  wb_txn_t exp_t;

  always @(negedge clk) begin
    if (wb.cyc === 1'b1) cyc_cnt++;
    if (timeout_o === 1'b1) to_cnt++;
    if (ext_data_oe === 1'b1) oe_cnt++;
    if (wb.ack === 1'b1) ack_cnt++;
    if (wb.cyc !== 1'b1) begin
      seen = 1'b0;
    end else if (wb.stb === 1'b1 && !seen) begin
      seen = 1'b1;
      check("wb_txn_expected", 32'(wb_q.size() > 0), 32'd1);
      if (wb_q.size() > 0) begin
        exp_t = wb_q.pop_front();
        check("wb_adr", wb.adr, exp_t.adr);
        check("wb_sel", 32'(wb.sel), 32'(exp_t.sel));
        check("wb_we", 32'(wb.we), 32'(exp_t.we));
        if (exp_t.we) check("wb_dat", wb.dat_w, exp_t.dat);
      end
    end
  end

  task automatic wait_nwait(input string tag, input int max);
    int i = 0;
    while (ext_nwait !== 1'b1 && i < max) begin
      tick(1);
      i++;
    end
    check(tag, 32'(ext_nwait), 32'd1);
  endtask

  task automatic host_write(input logic [12:0] a, input logic [7:0] d, input logic [3:0] s);
    wb_q.push_back('{adr: {BASE[31:13], a}, sel: s, dat: {4{d}}, we: 1'b1});
    ext_addr = a;
    ext_data_i = d;
    ext_ncs = 1'b0;
    tick(2);
    ext_nwe = 1'b0;
    tick(3);
    ext_nwe = 1'b1;
    tick(2);
    check("wr_stb_before", 32'(wb.stb), 32'd0);
    tick(1);
    check("wr_stb_latency", 32'(wb.stb), 32'd1);
    check("wr_nwait_busy", 32'(ext_nwait), 32'd0);
    wait_nwait("wr_nwait_done", 300);
    ext_ncs = 1'b1;
    tick(3);
  endtask

  task automatic host_read(input logic [12:0] a, input logic [7:0] d, input logic [3:0] s);
    int i = 0;
    wb_q.push_back('{adr: {BASE[31:13], a}, sel: s, dat: 32'd0, we: 1'b0});
    rd_q.push_back(d);
    ext_addr = a;
    ext_ncs = 1'b0;
    ext_noe = 1'b0;
    tick(2);
    check("rd_stb_before", 32'(wb.stb), 32'd0);
    tick(1);
    check("rd_stb_latency", 32'(wb.stb), 32'd1);
    check("rd_nwait_busy", 32'(ext_nwait), 32'd0);
    while (ext_data_oe !== 1'b1 && i < 400) begin
      tick(1);
      i++;
    end
    check("rd_oe", 32'(ext_data_oe), 32'd1);
    check("rd_data", 32'(ext_data_o), 32'(rd_q.pop_front()));
    check("rd_nwait_free", 32'(ext_nwait), 32'd1);
    tick(2);
    check("rd_oe_hold", 32'(ext_data_oe), 32'd1);
    ext_noe = 1'b1;
    ext_ncs = 1'b1;
    tick(4);
    check("rd_oe_release", 32'(ext_data_oe), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int c0, t0, o0, a0;
  int i;

  initial begin
    tick(3);
    check("rst_cyc", 32'(wb.cyc), 32'd0);
    check("rst_stb", 32'(wb.stb), 32'd0);
    check("rst_we", 32'(wb.we), 32'd0);
    check("rst_adr", wb.adr, 32'd0);
    check("rst_sel", 32'(wb.sel), 32'd0);
    check("rst_dat", wb.dat_w, 32'd0);
    check("rst_data_o", 32'(ext_data_o), 32'd0);
    check("rst_oe", 32'(ext_data_oe), 32'd0);
    check("rst_nwait", 32'(ext_nwait), 32'd1);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    reset = 1'b0;
    tick(2);

    host_write(13'h0005, 8'hA5, 4'b0100);
    host_read(13'h0003, 8'h44, 4'b0001);

    // Slave silent: abort after exactly 255 clocks of cyc, error byte returned.
    no_ack = 1'b1;
    c0 = cyc_cnt;
    t0 = to_cnt;
    host_read(13'h0002, 8'hFF, 4'b0010);
    check("to_cyc_clocks", 32'(cyc_cnt - c0), 32'd255);
    check("to_pulse_count", 32'(to_cnt - t0), 32'd1);
    no_ack = 1'b0;

    // Host releases before a slow ack: cycle still completes, pads never driven.
    ack_delay = 10;
    o0 = oe_cnt;
    a0 = ack_cnt;
    t0 = to_cnt;
    wb_q.push_back('{adr: {BASE[31:13], 13'h0007}, sel: 4'b0001, dat: 32'd0, we: 1'b0});
    ext_addr = 13'h0007;
    ext_ncs = 1'b0;
    ext_noe = 1'b0;
    tick(4);
    check("early_cyc_open", 32'(wb.cyc), 32'd1);
    ext_noe = 1'b1;
    ext_ncs = 1'b1;
    i = 0;
    while (wb.cyc === 1'b1 && i < 50) begin
      tick(1);
      i++;
    end
    check("early_cyc_done", 32'(wb.cyc), 32'd0);
    tick(3);
    check("early_acked", 32'(ack_cnt - a0), 32'd1);
    check("early_no_timeout", 32'(to_cnt - t0), 32'd0);
    check("early_oe_never", 32'(oe_cnt - o0), 32'd0);
    check("early_nwait", 32'(ext_nwait), 32'd1);
    ack_delay = 0;

    // Back-to-back through the memory.
    host_read(13'h0005, 8'hA5, 4'b0100);
    host_write(13'h0102, 8'h3C, 4'b0010);
    host_read(13'h0102, 8'h3C, 4'b0010);
    host_read(13'h0004, 8'h00, 4'b1000);

    // Reset while a read is outstanding.
    no_ack = 1'b1;
    wb_q.push_back('{adr: {BASE[31:13], 13'h0003}, sel: 4'b0001, dat: 32'd0, we: 1'b0});
    ext_addr = 13'h0003;
    ext_ncs = 1'b0;
    ext_noe = 1'b0;
    tick(5);
    check("rrst_cyc_before", 32'(wb.cyc), 32'd1);
    reset = 1'b1;
    ext_ncs = 1'b1;
    ext_noe = 1'b1;
    @(posedge clk);
    #1;
    check("rrst_cyc", 32'(wb.cyc), 32'd0);
    check("rrst_stb", 32'(wb.stb), 32'd0);
    check("rrst_adr", wb.adr, 32'd0);
    check("rrst_nwait", 32'(ext_nwait), 32'd1);
    check("rrst_oe", 32'(ext_data_oe), 32'd0);
    check("rrst_data_o", 32'(ext_data_o), 32'd0);
    check("rrst_timeout", 32'(timeout_o), 32'd0);
    tick(2);
    reset = 1'b0;
    no_ack = 1'b0;
    tick(4);
    check("rrst_idle_cyc", 32'(wb.cyc), 32'd0);

    check("wb_q_drained", 32'(wb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
